// File: rtl/key_scheduler.sv
// PS/2 scan-code decoder: E0/F0 prefix FSM, six held-key levels, event strobe and last-code capture.
// Build option KEY_TYPEMATIC_FILTER_EN suppresses events that do not change a key level.
module key_scheduler #(
  parameter int unsigned TIMEOUT_CYC = 25000000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [5:0]  keys,
  output logic        evt_valid,
  output logic        evt_make,
  output logic [2:0]  evt_idx,
  output logic [15:0] last_code,
  output logic        last_brk,
  output logic [1:0]  dbg_state
);

  // Handshake: rx_data is consumed on every cycle with rx_valid=1 (no backpressure);
  // evt_valid is a one-cycle strobe with evt_make/evt_idx valid alongside it.

  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, BRK = 2'd2, EXT_BRK = 2'd3} state_t;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          timeout;
  logic          done, done_ext, done_brk;
  logic          map_hit;
  logic [2:0]    map_idx;
  logic [5:0]    key_mask;
  logic          evt_fire;

  assign dbg_state = state;
  assign timeout   = (state != IDLE) && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  // A byte arriving on the timeout cycle still decodes in the current state.
  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    done_ext  = 1'b0;
    done_brk  = 1'b0;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_data == 8'hE0)      state_nxt = EXT;
          else if (rx_data == 8'hF0) state_nxt = BRK;
          else                       done = 1'b1;
        end
        EXT: begin
          if (rx_data == 8'hF0)      state_nxt = EXT_BRK;
          else if (rx_data != 8'hE0) begin
            done      = 1'b1;
            done_ext  = 1'b1;
            state_nxt = IDLE;
          end
        end
        BRK: begin
          if (rx_data != 8'hF0) begin
            done      = 1'b1;
            done_brk  = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: begin
          if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
            done      = 1'b1;
            done_ext  = 1'b1;
            done_brk  = 1'b1;
            state_nxt = IDLE;
          end
        end
      endcase
    end else if (timeout) begin
      state_nxt = IDLE;
    end
  end

  // Key map: the extended flag is part of the match.
  always_comb begin
    map_hit = 1'b1;
    map_idx = 3'd0;
    case ({done_ext, rx_data})
      9'h175:  map_idx = 3'd0;
      9'h172:  map_idx = 3'd1;
      9'h16B:  map_idx = 3'd2;
      9'h174:  map_idx = 3'd3;
      9'h029:  map_idx = 3'd4;
      9'h076:  map_idx = 3'd5;
      default: map_hit = 1'b0;
    endcase
  end

  assign key_mask = 6'b000001 << map_idx;

`ifdef KEY_TYPEMATIC_FILTER_EN
  assign evt_fire = done && map_hit &&
                    (done_brk ? |(keys & key_mask) : ~|(keys & key_mask));
`else
  assign evt_fire = done && map_hit;
`endif

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt       <= '0;
      keys      <= 6'b0;
      evt_valid <= 1'b0;
      evt_make  <= 1'b0;
      evt_idx   <= 3'd0;
      last_code <= 16'h0000;
      last_brk  <= 1'b0;
    end else begin
      if (rx_valid || state == IDLE || timeout) cnt <= '0;
      else                                      cnt <= cnt + CW'(1);
      evt_valid <= evt_fire;
      if (evt_fire) begin
        evt_make <= ~done_brk;
        evt_idx  <= map_idx;
      end
      if (done) begin
        last_code <= {(done_ext ? 8'hE0 : 8'h00), rx_data};
        last_brk  <= done_brk;
        if (map_hit) keys <= done_brk ? (keys & ~key_mask) : (keys | key_mask);
      end
    end
  end

endmodule
